vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Raster timing generator that produces the pixel coordinate and blanking interface consumed by bitmap_gen: pix_x, pix_y and video_on.
- Also drives the hsync/vsync pins of the VGA connector.
- Derives the pixel rate from the system clock with an integer divider.
- Emits per-line and per-frame strobes so drawing blocks can update state during blanking.

Parameters:
- CLK_DIV, 2, system clocks per pixel (1..16); 2 gives a 25 MHz pixel rate from a 50 MHz clk.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BACK, 48, horizontal back porch, in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BACK, 33, vertical back porch, in lines.
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- en  in  1  synchronous run enable; 0 holds the generator idle.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- video_on  out  1  high while (pixel_x, pixel_y) is in the visible area.
- p_tick  out  1  one-clk strobe per pixel; consumers sample pixel data here.
- pixel_x  out  10  current column.
- pixel_y  out  10  current line.
- line_tick  out  1  one-clk pulse when pixel_x returns to 0.
- frame_tick  out  1  one-clk pulse at (0, V_DISPLAY+1).
- frame_cnt  out  8  completed-frame counter.

Behaviour:
- Internal state:
  - div_cnt counts 0..CLK_DIV-1.
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of the four H params (800).
  - v_cnt counts 0..V_TOTAL-1, where V_TOTAL = sum of the four V params (525).
  - H_TOTAL and V_TOTAL must each be <= 1024; the implementation rejects larger values at elaboration.
- Divider and pixel strobe:
  - tick_i = en && (div_cnt == CLK_DIV-1).
  - div_cnt increments every clk while en=1 and wraps to 0 on tick_i.
  - With CLK_DIV=1, tick_i is constantly high while en=1.
- Counter advance:
  - On tick_i, h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At V_TOTAL-1, v_cnt wraps to 0 and frame_cnt increments (mod 256).
- Outputs are registered: one clk latency from the internal counters.
  - pixel_x <= h_cnt; pixel_y <= v_cnt.
  - video_on <= (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY) && en.
  - hsync <= SYNC_POL when h_cnt is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751), else ~SYNC_POL.
  - vsync <= SYNC_POL when v_cnt is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491), else ~SYNC_POL.
  - p_tick <= tick_i. It is therefore high in the last clk in which the current pixel_x/pixel_y is presented.
- Strobes:
  - line_tick: high for exactly one clk, the first clk in which output pixel_x == 0 after a wrap.
  - frame_tick: high for exactly one clk, the first clk in which output (pixel_x, pixel_y) == (0, V_DISPLAY+1).
  - Neither strobe fires for the initial (0,0) presented after reset or enable.
- en = 0 (synchronous):
  - div_cnt, h_cnt and v_cnt are cleared to 0 and held there.
  - Outputs: hsync/vsync = ~SYNC_POL, video_on = 0, p_tick = line_tick = frame_tick = 0, pixel_x = pixel_y = 0.
  - frame_cnt holds its value.
  - On re-enable, the scan restarts at (0,0) and the first tick_i occurs CLK_DIV clks later.
- Reset (asynchronous, any time including mid-frame):
  - All counters, pixel_x, pixel_y and frame_cnt go to 0.
  - hsync = vsync = ~SYNC_POL.
  - video_on, p_tick, line_tick and frame_tick go to 0.
  - After release with en=1, video_on goes high on the first clk edge and the timing restarts from (0,0).
- Frame period is H_TOTAL * V_TOTAL * CLK_DIV clks: 840000 at the defaults.

Test Plan:
1. Defaults, en=1 after reset -> hsync falling edges every 1600 clks, each pulse low for 192 clks; first falling edge when pixel_x becomes 656.
2. Defaults -> vsync low for exactly 3200 clks starting at pixel_y=490, pixel_x=0; frame_tick period 840000 clks; frame_cnt 0→1 at the first return to (0,0).
3. Defaults -> per line, video_on is high for 640 p_ticks; per frame, video_on high on 307200 p_ticks; video_on is never high when pixel_x>=640 or pixel_y>=480.
4. CLK_DIV=1, small timing (H params 8/2/2/2, V params 4/1/1/1), SYNC_POL=1 -> p_tick constant 1, hsync high at pixel_x 10..11, vsync high on line 5, frame period 98 clks.
5. Drop en at pixel_x=300, pixel_y=100, hold 50 clks, then re-raise -> while low: pixel_x=pixel_y=0, video_on=0, sync inactive, frame_cnt unchanged; after re-raise: scan restarts at (0,0) with first p_tick 2 clks later.
6. Assert reset mid-vsync (pixel_y=491) for 3 clks -> vsync returns high immediately, frame_cnt=0, no frame_tick or line_tick spike; after release, full-frame timing is identical to scenario 2.

Source files
------------

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel divider, h/v counters, syncs, blanking, strobes.
// Latency: all outputs registered, one clk behind the internal counters.
// No backpressure: free-running while en=1; en=0 clears the scan and idles outputs.
module vga_sync_gen #(
  parameter int   CLK_DIV   = 2,
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Counters are 10 bits wide, so both totals must fit in 0..1023.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must each be <= 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG     = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG     = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] FTICK_ROW  = 10'(V_DISPLAY + 1);
  localparam logic       SYNC_OFF   = ~SYNC_POL;

  logic [3:0] div_cnt;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       tick_i;
  logic       h_sync_on;
  logic       v_sync_on;

  assign tick_i    = en && (div_cnt == DIV_LAST);
  assign h_sync_on = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
  assign v_sync_on = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);

  // Pixel divider and raster counters; frame_cnt bumps when the scan wraps to (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (!en) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (tick_i) begin
      div_cnt <= '0;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // Registered raster outputs; strobes fire only when pixel_x drops back to 0 from a
  // non-zero column, so the (0,0) shown after reset or enable never triggers them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x    <= '0;
      pixel_y    <= '0;
      video_on   <= 1'b0;
      hsync      <= SYNC_OFF;
      vsync      <= SYNC_OFF;
      p_tick     <= 1'b0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pixel_x    <= en ? h_cnt : '0;
      pixel_y    <= en ? v_cnt : '0;
      video_on   <= en && (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hsync      <= (en && h_sync_on) ? SYNC_POL : SYNC_OFF;
      vsync      <= (en && v_sync_on) ? SYNC_POL : SYNC_OFF;
      p_tick     <= tick_i;
      line_tick  <= en && (h_cnt == '0) && (pixel_x != '0);
      frame_tick <= en && (h_cnt == '0) && (v_cnt == FTICK_ROW) && (pixel_x != '0);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing (line level), a reduced CLK_DIV=2
// raster (frame level, vsync, mid-vsync reset) and a tiny CLK_DIV=1 active-high raster.
// Outputs sampled on the falling clock edge; k counts rising edges since reset release.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic d_hs, d_vs, d_vo, d_pt, d_lt, d_ft;
  logic [9:0] d_px, d_py;
  logic [7:0] d_fc;
  // reduced instance: CLK_DIV=2, H 16/4/8/4 = 32, V 12/2/2/4 = 20, frame 1280 clks
  logic m_hs, m_vs, m_vo, m_pt, m_lt, m_ft;
  logic [9:0] m_px, m_py;
  logic [7:0] m_fc;
  // small instance: CLK_DIV=1, H 8/2/2/2 = 14, V 4/1/1/1 = 7, active-high syncs, frame 98 clks
  logic s_hs, s_vs, s_vo, s_pt, s_lt, s_ft;
  logic [9:0] s_px, s_py;
  logic [7:0] s_fc;

  vga_sync_gen u_def (
    .clk(clk), .reset(reset), .en(en), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
    .p_tick(d_pt), .pixel_x(d_px), .pixel_y(d_py), .line_tick(d_lt),
    .frame_tick(d_ft), .frame_cnt(d_fc));

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4), .SYNC_POL(1'b0)
  ) u_mid (
    .clk(clk), .reset(reset), .en(en), .hsync(m_hs), .vsync(m_vs), .video_on(m_vo),
    .p_tick(m_pt), .pixel_x(m_px), .pixel_y(m_py), .line_tick(m_lt),
    .frame_tick(m_ft), .frame_cnt(m_fc));

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
  ) u_sml (
    .clk(clk), .reset(reset), .en(en), .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
    .p_tick(s_pt), .pixel_x(s_px), .pixel_y(s_py), .line_tick(s_lt),
    .frame_tick(s_ft), .frame_cnt(s_fc));

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // statistics gathered by measure()
  int d_hfall1, d_hfall2, d_hfall_px, d_hlow, d_vis, d_viol, d_lt1, d_lt_px, d_lt_py;
  int d_vo1, d_pt1, d_px1, s_pt1;
  int m_vfall1, m_vfall_px, m_vfall_py, m_vlow, m_ft1, m_ft2, m_vis;
  int m_fc1279, m_fc1281, m_px1281, m_py1281;
  int s_pt0, s_hs_bad, s_vs_bad, s_vs_hi, s_ft1, s_ftn;

  task automatic measure(input int ncyc);
    logic d_hs_prev, m_vs_prev;
    d_hfall1 = -1; d_hfall2 = -1; d_hfall_px = -1; d_hlow = 0; d_vis = 0; d_viol = 0;
    d_lt1 = -1; d_lt_px = -1; d_lt_py = -1;
    d_vo1 = -1; d_pt1 = -1; d_px1 = -1; s_pt1 = -1;
    m_vfall1 = -1; m_vfall_px = -1; m_vfall_py = -1; m_vlow = 0; m_ft1 = -1; m_ft2 = -1;
    m_vis = 0; m_fc1279 = -1; m_fc1281 = -1; m_px1281 = -1; m_py1281 = -1;
    s_pt0 = 0; s_hs_bad = 0; s_vs_bad = 0; s_vs_hi = 0; s_ft1 = -1; s_ftn = 0;
    d_hs_prev = 1'b1;
    m_vs_prev = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        d_vo1 = int'(d_vo); d_pt1 = int'(d_pt); d_px1 = int'(d_px); s_pt1 = int'(s_pt);
      end
      if (d_hs_prev && !d_hs) begin
        if (d_hfall1 < 0) begin d_hfall1 = k; d_hfall_px = int'(d_px); end
        else if (d_hfall2 < 0) d_hfall2 = k;
      end
      d_hs_prev = d_hs;
      if (k <= 1600 && !d_hs) d_hlow++;
      if (k <= 1600 && d_pt && d_vo) d_vis++;
      if (d_vo && (d_px >= 10'd640 || d_py >= 10'd480)) d_viol++;
      if (d_lt && d_lt1 < 0) begin d_lt1 = k; d_lt_px = int'(d_px); d_lt_py = int'(d_py); end

      if (m_vs_prev && !m_vs && m_vfall1 < 0) begin
        m_vfall1 = k; m_vfall_px = int'(m_px); m_vfall_py = int'(m_py);
      end
      m_vs_prev = m_vs;
      if (k <= 1280 && !m_vs) m_vlow++;
      if (k <= 1280 && m_pt && m_vo) m_vis++;
      if (m_ft) begin
        if (m_ft1 < 0) m_ft1 = k;
        else if (m_ft2 < 0) m_ft2 = k;
      end
      if (k == 1279) m_fc1279 = int'(m_fc);
      if (k == 1281) begin m_fc1281 = int'(m_fc); m_px1281 = int'(m_px); m_py1281 = int'(m_py); end

      if (!s_pt) s_pt0++;
      if (s_hs !== (s_px >= 10'd10 && s_px <= 10'd11)) s_hs_bad++;
      if (s_vs !== (s_py == 10'd5)) s_vs_bad++;
      if (k <= 98 && s_vs) s_vs_hi++;
      if (s_ft) begin s_ftn++; if (s_ft1 < 0) s_ft1 = k; end
    end
  endtask

  int found, idle_bad, fc_bad, spike;

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_d_hsync", d_hs, 1);
    chk("rst_d_vsync", d_vs, 1);
    chk("rst_d_video_on", d_vo, 0);
    chk("rst_d_p_tick", d_pt, 0);
    chk("rst_d_pixel_x", d_px, 0);
    chk("rst_d_frame_cnt", d_fc, 0);
    chk("rst_s_hsync_inactive_low", s_hs, 0);
    chk("rst_s_vsync_inactive_low", s_vs, 0);

    // ---- free run from reset release ----
    reset = 1'b0;
    measure(3200);
    chk("d_video_on_first_edge", d_vo1, 1);
    chk("d_p_tick_first_edge", d_pt1, 0);
    chk("d_pixel_x_first_edge", d_px1, 0);
    chk("d_hsync_first_fall_clk", d_hfall1, 1313);
    chk("d_hsync_first_fall_px", d_hfall_px, 656);
    chk("d_hsync_second_fall_clk", d_hfall2, 2913);
    chk("d_hsync_low_clks", d_hlow, 192);
    chk("d_visible_ticks_line0", d_vis, 640);
    chk("d_video_on_outside", d_viol, 0);
    chk("d_line_tick_clk", d_lt1, 1601);
    chk("d_line_tick_px", d_lt_px, 0);
    chk("d_line_tick_py", d_lt_py, 1);
    chk("d_frame_cnt_3200", d_fc, 0);
    chk("m_vsync_fall_clk", m_vfall1, 897);
    chk("m_vsync_fall_px", m_vfall_px, 0);
    chk("m_vsync_fall_py", m_vfall_py, 14);
    chk("m_vsync_low_clks", m_vlow, 128);
    chk("m_frame_tick_first", m_ft1, 833);
    chk("m_frame_tick_second", m_ft2, 2113);
    chk("m_visible_ticks_frame", m_vis, 192);
    chk("m_frame_cnt_before_wrap", m_fc1279, 0);
    chk("m_frame_cnt_at_00", m_fc1281, 1);
    chk("m_px_at_wrap", m_px1281, 0);
    chk("m_py_at_wrap", m_py1281, 0);
    chk("m_frame_cnt_3200", m_fc, 2);
    chk("s_p_tick_first_edge", s_pt1, 1);
    chk("s_p_tick_zero_clks", s_pt0, 0);
    chk("s_hsync_window", s_hs_bad, 0);
    chk("s_vsync_window", s_vs_bad, 0);
    chk("s_vsync_high_clks", s_vs_hi, 14);
    chk("s_frame_tick_first", s_ft1, 71);
    chk("s_frame_tick_count", s_ftn, 32);
    chk("s_frame_cnt_3200", s_fc, 32);

    // ---- en drop at pixel_x=300, hold 50 clks, re-raise ----
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (d_px == 10'd300) found = 1;
    end
    chk("wait_px300", found, 1);
    chk("en_pre_s_frame_cnt", s_fc, 6);
    en = 1'b0;
    idle_bad = 0;
    fc_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d_px != 10'd0 || d_py != 10'd0 || d_vo || !d_hs || !d_vs || d_pt || d_lt || d_ft)
        idle_bad++;
      if (m_vo || m_pt || !m_hs || !m_vs || s_pt || s_hs || s_vs) idle_bad++;
      if (s_fc != 8'd6) fc_bad++;
    end
    chk("en_low_idle_outputs", idle_bad, 0);
    chk("en_low_frame_cnt_hold", fc_bad, 0);
    en = 1'b1;
    @(negedge clk);
    chk("reen_e1_p_tick", d_pt, 0);
    chk("reen_e1_video_on", d_vo, 1);
    chk("reen_e1_pixel_x", d_px, 0);
    chk("reen_e1_s_p_tick", s_pt, 1);
    @(negedge clk);
    chk("reen_e2_p_tick", d_pt, 1);
    chk("reen_e2_pixel_x", d_px, 0);
    @(negedge clk);
    chk("reen_e3_pixel_x", d_px, 1);
    chk("reen_e3_line_tick", d_lt, 0);

    // ---- asynchronous reset in the second vsync line ----
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (m_py == 10'd15) found = 1;
    end
    chk("wait_m_py15", found, 1);
    chk("m_vsync_active_before_rst", m_vs, 0);
    reset = 1'b1;
    #1;
    chk("arst_m_vsync", m_vs, 1);
    chk("arst_m_frame_cnt", m_fc, 0);
    chk("arst_m_pixel_y", m_py, 0);
    chk("arst_m_strobes", {m_ft, m_lt, m_vo}, 0);
    spike = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_ft || m_lt || m_pt || !m_vs) spike++;
    end
    chk("arst_hold_no_spike", spike, 0);
    reset = 1'b0;
    measure(2200);
    chk("rst2_m_vsync_fall_clk", m_vfall1, 897);
    chk("rst2_m_vsync_fall_py", m_vfall_py, 14);
    chk("rst2_m_vsync_low_clks", m_vlow, 128);
    chk("rst2_m_frame_tick_first", m_ft1, 833);
    chk("rst2_m_frame_tick_second", m_ft2, 2113);
    chk("rst2_m_visible_ticks", m_vis, 192);
    chk("rst2_m_frame_cnt_at_00", m_fc1281, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
